// File: rtl/wash_pkg.sv
// Shared constants for the wash timer/level stimulus block: timer state
// codes, default durations and default counter widths.
package wash_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CYCLE_RUN  = 3'd1;
    localparam logic [2:0] ST_CYCLE_DONE = 3'd2;
    localparam logic [2:0] ST_SPIN_RUN   = 3'd3;
    localparam logic [2:0] ST_SPIN_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        CYCLE_RUN  = ST_CYCLE_RUN,
        CYCLE_DONE = ST_CYCLE_DONE,
        SPIN_RUN   = ST_SPIN_RUN,
        SPIN_DONE  = ST_SPIN_DONE
    } timer_state_e;

    localparam int DEF_TICK_DIV  = 4;
    localparam int DEF_CYCLE_SEC = 3;
    localparam int DEF_SPIN_SEC  = 2;
    localparam int DEF_LEVEL_MAX = 5;

    localparam int DEF_TW = 8;
    localparam int DEF_LW = 4;

endpackage

// File: rtl/wash_timer_level_unit_if.sv
// Controller-facing bundle: actuator commands in, sensor/timeout indications out.
interface wash_timer_level_unit_if
    import wash_pkg::*;
#(
    parameter int TW = DEF_TW,
    parameter int LW = DEF_LW
);

    logic          fill_valve_on;
    logic          drain_valve_on;
    logic          cycle_en;
    logic          spin_en;
    logic          filled;
    logic          drained;
    logic          cycle_timeout;
    logic          spin_timeout;
    logic [LW-1:0] level;
    logic [TW-1:0] seconds_left;

    // Controller side drives the actuators and watches the sensors.
    modport master (
        output fill_valve_on, drain_valve_on, cycle_en, spin_en,
        input  filled, drained, cycle_timeout, spin_timeout, level, seconds_left
    );

    modport slave (
        input  fill_valve_on, drain_valve_on, cycle_en, spin_en,
        output filled, drained, cycle_timeout, spin_timeout, level, seconds_left
    );

endinterface

// File: rtl/wash_tick_gen.sv
// Free-running prescaler: one-clock tick every TICK_DIV clocks, the first one
// in clock TICK_DIV after reset release.
module wash_tick_gen
    import wash_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] tick_cnt_q;
    logic [CW-1:0] tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q + CW'(1);
        if (tick_cnt_q == LAST) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_o = (tick_cnt_q == LAST);

endmodule

// File: rtl/wash_timer_level_unit.sv
// Stimulus stage for the washing-machine controller: models water level from
// the valve commands and times agitation/spin phases in prescaled seconds.
module wash_timer_level_unit
    import wash_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int CYCLE_SEC = DEF_CYCLE_SEC,
    parameter int SPIN_SEC  = DEF_SPIN_SEC,
    parameter int LEVEL_MAX = DEF_LEVEL_MAX,
    parameter int TW        = DEF_TW,
    parameter int LW        = DEF_LW
) (
    input  logic                    clk,
    input  logic                    reset,
    wash_timer_level_unit_if.slave  bus
);

    localparam logic [LW-1:0] LVL_FULL  = LW'(LEVEL_MAX);
    localparam logic [TW-1:0] CYCLE_CNT = TW'(CYCLE_SEC);
    localparam logic [TW-1:0] SPIN_CNT  = TW'(SPIN_SEC);

    logic tick;

    wash_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          fill_only;
    logic          drain_only;

    assign fill_only  = bus.fill_valve_on && !bus.drain_valve_on;
    assign drain_only = bus.drain_valve_on && !bus.fill_valve_on;

    // Both valves open (or neither) leaves the level untouched.
    always_comb begin
        level_d = level_q;
        if (tick) begin
            if (fill_only && (level_q < LVL_FULL)) begin
                level_d = level_q + LW'(1);
            end else if (drain_only && (level_q != '0)) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    timer_state_e  state_q;
    timer_state_e  state_d;
    timer_state_e  done_state;
    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;
    logic          run_en;

    assign run_en     = (state_q == CYCLE_RUN) ? bus.cycle_en : bus.spin_en;
    assign done_state = (state_q == CYCLE_RUN) ? CYCLE_DONE : SPIN_DONE;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (bus.cycle_en) begin
                    state_d = CYCLE_RUN;
                    count_d = CYCLE_CNT;
                end else if (bus.spin_en) begin
                    state_d = SPIN_RUN;
                    count_d = SPIN_CNT;
                end
            end
            CYCLE_RUN, SPIN_RUN: begin
                // Dropping the enable aborts silently, even on a tick clock.
                if (!run_en) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q == '0) begin
                    state_d = done_state;
                end else if (tick) begin
                    if (count_q == TW'(1)) begin
                        state_d = done_state;
                        count_d = '0;
                    end else begin
                        count_d = count_q - TW'(1);
                    end
                end
            end
            CYCLE_DONE: begin
                count_d = '0;
                if (!bus.cycle_en) begin
                    state_d = IDLE;
                end
            end
            SPIN_DONE: begin
                count_d = '0;
                if (!bus.spin_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.filled        = (level_q == LVL_FULL);
    assign bus.drained       = (level_q == '0);
    assign bus.cycle_timeout = (state_q == CYCLE_DONE);
    assign bus.spin_timeout  = (state_q == SPIN_DONE);
    assign bus.level         = level_q;
    assign bus.seconds_left  = count_q;

endmodule
